// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port among ALU, load and jal-link writebacks.
// Optional pending-write hazard detection is built when REGARB_HAZARD_EN is defined.
module regfile_write_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  aluValid,
  output logic                  aluReady,
  input  logic [ADDR_WIDTH-1:0] aluReg,
  input  logic [DATA_WIDTH-1:0] aluData,
  input  logic                  memValid,
  output logic                  memReady,
  input  logic [ADDR_WIDTH-1:0] memReg,
  input  logic [DATA_WIDTH-1:0] memData,
  input  logic                  jal,
  output logic                  jalReady,
  input  logic [DATA_WIDTH-1:0] PC,
  output logic                  regWrite,
  output logic [ADDR_WIDTH-1:0] writeRegister,
  output logic [DATA_WIDTH-1:0] writeData,
  input  logic [ADDR_WIDTH-1:0] readRegister1,
  input  logic [ADDR_WIDTH-1:0] readRegister2,
  output logic                  stall
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [ADDR_WIDTH-1:0] LINK_REG = ADDR_WIDTH'(31);

  logic [ADDR_WIDTH-1:0] r_alu_reg  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_alu_data [FIFO_DEPTH];
  logic [PW-1:0]         r_alu_rd, r_alu_wr;
  logic [CW-1:0]         r_alu_cnt;
  logic [ADDR_WIDTH-1:0] r_mem_reg  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic [PW-1:0]         r_mem_rd, r_mem_wr;
  logic [CW-1:0]         r_mem_cnt;
  logic                  r_jal_pend;
  logic [DATA_WIDTH-1:0] r_jal_link;
  logic                  r_rr_last_mem;
  logic                  r_reg_write;
  logic [ADDR_WIDTH-1:0] r_write_reg;
  logic [DATA_WIDTH-1:0] r_write_data;

  logic w_alu_push, w_mem_push, w_jal_push;
  logic w_alu_ne, w_mem_ne;
  logic w_gnt_jal, w_gnt_alu, w_gnt_mem;

  assign aluReady = (r_alu_cnt < CW'(FIFO_DEPTH));
  assign memReady = (r_mem_cnt < CW'(FIFO_DEPTH));
  assign jalReady = !r_jal_pend;

  // Register-0 requests complete the handshake but never enter a queue.
  assign w_alu_push = aluValid && aluReady && (aluReg != '0);
  assign w_mem_push = memValid && memReady && (memReg != '0);
  assign w_jal_push = jal && !r_jal_pend;

  assign w_alu_ne  = (r_alu_cnt != '0);
  assign w_mem_ne  = (r_mem_cnt != '0);
  assign w_gnt_jal = r_jal_pend;
  assign w_gnt_alu = !r_jal_pend && w_alu_ne && (!w_mem_ne || r_rr_last_mem);
  assign w_gnt_mem = !r_jal_pend && w_mem_ne && (!w_alu_ne || !r_rr_last_mem);

  // Queue storage: payload only, validity tracked by pointers/counts.
  always_ff @(posedge clk) begin
    if (w_alu_push) begin
      r_alu_reg[r_alu_wr]  <= aluReg;
      r_alu_data[r_alu_wr] <= aluData;
    end
    if (w_mem_push) begin
      r_mem_reg[r_mem_wr]  <= memReg;
      r_mem_data[r_mem_wr] <= memData;
    end
    if (w_jal_push) r_jal_link <= PC + DATA_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_rd      <= '0;
      r_alu_wr      <= '0;
      r_alu_cnt     <= '0;
      r_mem_rd      <= '0;
      r_mem_wr      <= '0;
      r_mem_cnt     <= '0;
      r_jal_pend    <= 1'b0;
      r_rr_last_mem <= 1'b1;
    end else begin
      if (w_alu_push) r_alu_wr <= r_alu_wr + PW'(1);
      if (w_gnt_alu)  r_alu_rd <= r_alu_rd + PW'(1);
      if (w_alu_push && !w_gnt_alu)      r_alu_cnt <= r_alu_cnt + CW'(1);
      else if (!w_alu_push && w_gnt_alu) r_alu_cnt <= r_alu_cnt - CW'(1);
      if (w_mem_push) r_mem_wr <= r_mem_wr + PW'(1);
      if (w_gnt_mem)  r_mem_rd <= r_mem_rd + PW'(1);
      if (w_mem_push && !w_gnt_mem)      r_mem_cnt <= r_mem_cnt + CW'(1);
      else if (!w_mem_push && w_gnt_mem) r_mem_cnt <= r_mem_cnt - CW'(1);
      // A pending link is always granted, so it lives exactly one cycle.
      r_jal_pend <= r_jal_pend ? 1'b0 : jal;
      if (w_gnt_alu)      r_rr_last_mem <= 1'b0;
      else if (w_gnt_mem) r_rr_last_mem <= 1'b1;
    end
  end

  // Registered write-port stage; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else begin
      r_reg_write <= w_gnt_jal || w_gnt_alu || w_gnt_mem;
      if (w_gnt_jal) begin
        r_write_reg  <= LINK_REG;
        r_write_data <= r_jal_link;
      end else if (w_gnt_alu) begin
        r_write_reg  <= r_alu_reg[r_alu_rd];
        r_write_data <= r_alu_data[r_alu_rd];
      end else if (w_gnt_mem) begin
        r_write_reg  <= r_mem_reg[r_mem_rd];
        r_write_data <= r_mem_data[r_mem_rd];
      end
    end
  end

  assign regWrite      = r_reg_write;
  assign writeRegister = r_write_reg;
  assign writeData     = r_write_data;

`ifdef REGARB_HAZARD_EN
  logic w_hit1, w_hit2;

  always_comb begin
    w_hit1 = r_jal_pend && (readRegister1 == LINK_REG);
    w_hit2 = r_jal_pend && (readRegister2 == LINK_REG);
    if (r_reg_write && (r_write_reg == readRegister1)) w_hit1 = 1'b1;
    if (r_reg_write && (r_write_reg == readRegister2)) w_hit2 = 1'b1;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      if (CW'(k) < r_alu_cnt) begin
        if (r_alu_reg[r_alu_rd + PW'(k)] == readRegister1) w_hit1 = 1'b1;
        if (r_alu_reg[r_alu_rd + PW'(k)] == readRegister2) w_hit2 = 1'b1;
      end
      if (CW'(k) < r_mem_cnt) begin
        if (r_mem_reg[r_mem_rd + PW'(k)] == readRegister1) w_hit1 = 1'b1;
        if (r_mem_reg[r_mem_rd + PW'(k)] == readRegister2) w_hit2 = 1'b1;
      end
    end
  end

  assign stall = (w_hit1 && (readRegister1 != '0)) || (w_hit2 && (readRegister2 != '0));
`else
  logic w_unused_rd;
  assign w_unused_rd = ^{readRegister1, readRegister2};
  assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed-vector bench for regfile_write_arbiter (default parameters).
module tb_regfile_write_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
`ifdef REGARB_HAZARD_EN
  localparam logic HZ = 1'b1;
`else
  localparam logic HZ = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          aluValid, memValid, jal;
  logic          aluReady, memReady, jalReady;
  logic [AW-1:0] aluReg, memReg, writeRegister, readRegister1, readRegister2;
  logic [DW-1:0] aluData, memData, PC, writeData;
  logic          regWrite, stall;

  int n_vec = 0;
  int n_err = 0;

  regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .aluValid(aluValid), .aluReady(aluReady), .aluReg(aluReg), .aluData(aluData),
    .memValid(memValid), .memReady(memReady), .memReg(memReg), .memData(memData),
    .jal(jal), .jalReady(jalReady), .PC(PC),
    .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
    .readRegister1(readRegister1), .readRegister2(readRegister2), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    aluValid = 1'b0; memValid = 1'b0; jal = 1'b0;
    aluReg = '0; memReg = '0; aluData = '0; memData = '0; PC = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic rw, input logic [AW-1:0] wr,
                         input logic [DW-1:0] wd);
    chk({tag, ".rw"}, DW'(regWrite), DW'(rw));
    chk({tag, ".wr"}, DW'(writeRegister), DW'(wr));
    chk({tag, ".wd"}, writeData, wd);
  endtask

  initial begin
    readRegister1 = '0; readRegister2 = '0;
    do_reset();
    step();
    do_reset();
    chk_out("rst", 1'b0, 5'd0, 32'h0);
    chk("rst.stall", DW'(stall), 32'h0);
    chk("rst.aluRdy", DW'(aluReady), 32'h1);
    chk("rst.memRdy", DW'(memReady), 32'h1);
    chk("rst.jalRdy", DW'(jalReady), 32'h1);

    // single ALU write
    aluValid = 1'b1; aluReg = 5'd5; aluData = 32'hDEADBEEF;
    step();
    aluValid = 1'b0;
    chk("single.pre", DW'(regWrite), 32'h0);
    step();
    chk_out("single", 1'b1, 5'd5, 32'hDEADBEEF);
    step();
    chk_out("single.after", 1'b0, 5'd5, 32'hDEADBEEF);

    // ALU vs MEM contention
    do_reset();
    aluValid = 1'b1; aluReg = 5'd3; aluData = 32'h11;
    memValid = 1'b1; memReg = 5'd4; memData = 32'h22;
    step();
    idle_inputs();
    step(); chk_out("cont.1", 1'b1, 5'd3, 32'h11);
    step(); chk_out("cont.2", 1'b1, 5'd4, 32'h22);
    step(); chk("cont.idle", DW'(regWrite), 32'h0);

    // link priority then round-robin
    do_reset();
    aluValid = 1'b1; aluReg = 5'd1; aluData = 32'hA1;
    memValid = 1'b1; memReg = 5'd2; memData = 32'hB1;
    jal = 1'b1; PC = 32'h100;
    step();
    jal = 1'b0;
    aluReg = 5'd5; aluData = 32'hA2;
    memReg = 5'd6; memData = 32'hB2;
    chk("rr.aluRdy", DW'(aluReady), 32'h1);
    chk("rr.memRdy", DW'(memReady), 32'h1);
    step();
    idle_inputs();
    chk_out("rr.link", 1'b1, 5'd31, 32'h101);
    step(); chk_out("rr.alu1", 1'b1, 5'd1, 32'hA1);
    step(); chk_out("rr.mem1", 1'b1, 5'd2, 32'hB1);
    step(); chk_out("rr.alu2", 1'b1, 5'd5, 32'hA2);
    step(); chk_out("rr.mem2", 1'b1, 5'd6, 32'hB2);
    step(); chk("rr.idle", DW'(regWrite), 32'h0);

    // backpressure: all sources held busy, MEM fills after two acceptances
    do_reset();
    aluValid = 1'b1; aluReg = 5'd8; aluData = 32'hC8;
    memValid = 1'b1; memReg = 5'd9; memData = 32'hC9;
    jal = 1'b1; PC = 32'h200;
    chk("bp.memRdy0", DW'(memReady), 32'h1);
    step(); chk("bp.memRdy1", DW'(memReady), 32'h1);
    step(); chk("bp.memRdy2", DW'(memReady), 32'h0);
    chk("bp.aluRdy2", DW'(aluReady), 32'h0);
    chk_out("bp.link", 1'b1, 5'd31, 32'h201);
    step(); chk("bp.memRdy3", DW'(memReady), 32'h0);
    chk_out("bp.alu", 1'b1, 5'd8, 32'hC8);

    // reset with writes still pending: all of them must vanish
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst.rw", DW'(regWrite), 32'h0);
    chk("mrst.aluRdy", DW'(aluReady), 32'h1);
    chk("mrst.memRdy", DW'(memReady), 32'h1);
    chk("mrst.jalRdy", DW'(jalReady), 32'h1);
    chk("mrst.stall", DW'(stall), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mrst.drop", DW'(regWrite), 32'h0);
    end

    // register 0 is accepted but never written
    do_reset();
    aluValid = 1'b1; aluReg = 5'd0; aluData = 32'h55;
    chk("r0.aluRdy", DW'(aluReady), 32'h1);
    step();
    aluValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("r0.none", 1'b0, 5'd0, 32'h0);
    end

    // hazard on a pending r7 write
    do_reset();
    readRegister1 = 5'd7; readRegister2 = 5'd0;
    aluValid = 1'b1; aluReg = 5'd7; aluData = 32'h77;
    chk("hz.empty", DW'(stall), 32'h0);
    step();
    aluValid = 1'b0;
    chk("hz.queued", DW'(stall), DW'(HZ));
    step();
    chk("hz.outrw", DW'(regWrite), 32'h1);
    chk("hz.outstage", DW'(stall), DW'(HZ));
    step();
    chk("hz.cleared", DW'(stall), 32'h0);

    // read address 0 never stalls; link register hazard via port 2
    readRegister1 = 5'd0; readRegister2 = 5'd0;
    aluValid = 1'b1; aluReg = 5'd3; aluData = 32'h33;
    jal = 1'b1; PC = 32'h40;
    step();
    idle_inputs();
    chk("hz.zero", DW'(stall), 32'h0);
    readRegister2 = 5'd31;
    #1;
    chk("hz.link", DW'(stall), DW'(HZ));
    readRegister2 = 5'd0;
    step(); chk_out("hz.linkw", 1'b1, 5'd31, 32'h41);
    step(); chk_out("hz.aluw", 1'b1, 5'd3, 32'h33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
